// File: rtl/mem_1r1w_masked_param.sv
// mem_1r1w_masked_param
// Parametrised single-clock 1R1W memory with per-lane write mask, write-first
// same-cycle forwarding, out-of-range protection and 1- or 2-cycle read latency.
// Optional feature macro: MEM_1R1W_MASKED_PARAM_INIT_CLEAR_EN
//   defined   -> post-reset zero-fill sequencer, init_busy high for DEPTH cycles
//   undefined -> no sequencer, init_busy tied low, array content undefined at start
module mem_1r1w_masked_param #(
   parameter int DEPTH        = 48,
   parameter int WIDTH        = 64,
   parameter int MASK_GRAN    = 8,
   parameter int READ_LATENCY = 1,
   localparam int ADDR_W      = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int MASK_W      = WIDTH / MASK_GRAN
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] R0_addr,
   input  logic              R0_en,
   output logic [WIDTH-1:0]  R0_data,
   output logic              R0_valid,
   input  logic [ADDR_W-1:0] W0_addr,
   input  logic              W0_en,
   input  logic [WIDTH-1:0]  W0_data,
   input  logic [MASK_W-1:0] W0_mask,
   output logic              init_busy
);

   // Depth widened by one bit so the range check also works for power-of-two depths
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
      $error("mem_1r1w_masked_param: WIDTH must be a multiple of MASK_GRAN");
   end
   if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
      $error("mem_1r1w_masked_param: READ_LATENCY must be 1 or 2");
   end

   logic              w_init_busy;
   logic              w_init_we;
   logic [ADDR_W-1:0] w_init_addr;

`ifdef MEM_1R1W_MASKED_PARAM_INIT_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   // Reset lands directly in FILL so init_busy is high exactly DEPTH cycles
   typedef enum logic {S_FILL = 1'b0, S_DONE = 1'b1} state_t;
   state_t            r_state;
   state_t            w_state_next;
   logic [ADDR_W-1:0] r_fill_cnt;

   // State register and fill counter; reset mid-fill restarts from word 0
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state    <= S_FILL;
         r_fill_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == S_FILL && r_fill_cnt != LAST_ADDR) begin
            r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
         end
      end
   end

   // Next state: leave FILL after the last word is written, DONE is absorbing
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_FILL: if (r_fill_cnt == LAST_ADDR) w_state_next = S_DONE;
         S_DONE: w_state_next = S_DONE;
      endcase
   end

   // Outputs: one zero word per FILL cycle at the counter address
   always_comb begin
      w_init_busy = (r_state == S_FILL);
      w_init_we   = (r_state == S_FILL);
      w_init_addr = r_fill_cnt;
   end
`else
   assign w_init_busy = 1'b0;
   assign w_init_we   = 1'b0;
   assign w_init_addr = '0;
`endif

   assign init_busy = w_init_busy;

   // Request qualification; out-of-range reads still return a (zero) response
   logic w_rd_fire;
   logic w_rd_in_range;
   logic w_wr_acc;
   logic w_fwd;

   assign w_rd_in_range = ({1'b0, R0_addr} < DEPTH_X);
   assign w_rd_fire     = R0_en & ~w_init_busy;
   assign w_wr_acc      = W0_en & ~w_init_busy & ({1'b0, W0_addr} < DEPTH_X);
   assign w_fwd         = w_wr_acc & (W0_addr == R0_addr);

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [MASK_W-1:0] w_mem_lane;
   logic [WIDTH-1:0]  w_mem_wdata;

   // Write port: fill sequencer owns it while busy, otherwise the W0 port
   always_comb begin
      w_mem_we    = w_wr_acc;
      w_mem_addr  = W0_addr;
      w_mem_lane  = W0_mask;
      w_mem_wdata = W0_data;
      if (w_init_we) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = w_init_addr;
         w_mem_lane  = '1;
         w_mem_wdata = '0;
      end
   end

   // One narrow array per mask lane keeps each lane a plain RAM with its own enable
   logic [WIDTH-1:0] w_rd_word;

   for (genvar gi = 0; gi < MASK_W; gi++) begin : g_lane
      logic [MASK_GRAN-1:0] r_lane [DEPTH];

      // Lane write, no reset: contents survive reset unless the fill runs
      always_ff @(posedge clock) begin
         if (w_mem_we && w_mem_lane[gi]) begin
            r_lane[w_mem_addr] <= w_mem_wdata[gi*MASK_GRAN +: MASK_GRAN];
         end
      end

      // Read lane with write-first forwarding; out-of-range reads yield zero
      assign w_rd_word[gi*MASK_GRAN +: MASK_GRAN] =
         !w_rd_in_range          ? '0 :
         (w_fwd && W0_mask[gi])  ? W0_data[gi*MASK_GRAN +: MASK_GRAN] :
                                   r_lane[R0_addr];
   end

   logic [WIDTH-1:0] r_data_out;
   logic             r_valid_out;

   if (READ_LATENCY == 2) begin : g_lat2
      logic [WIDTH-1:0] r_s1_data;
      logic             r_s1_valid;

      // Stage 1: capture the read word at the request edge
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
         end else begin
            r_s1_valid <= w_rd_fire;
            if (w_rd_fire) r_s1_data <= w_rd_word;
         end
      end

      // Output stage: publish stage-1 result, hold data until the next response
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
         end else begin
            r_valid_out <= r_s1_valid;
            if (r_s1_valid) r_data_out <= r_s1_data;
         end
      end
   end else begin : g_lat1
      // Single stage: the capture register is the output, held until the next read
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
         end else begin
            r_valid_out <= w_rd_fire;
            if (w_rd_fire) r_data_out <= w_rd_word;
         end
      end
   end

   assign R0_data  = r_data_out;
   assign R0_valid = r_valid_out;

endmodule
